// File: rtl/teclado_escaner.sv
// 4x4 matrix keypad scanner with two-flop row synchronizer and press/release
// debounce; emits one DIGITO_STB per physical key press.
module teclado_escaner #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] FILAS,
  output logic [3:0] COLUMNAS,
  output logic [3:0] DIGITO,
  output logic       DIGITO_STB,
  output logic       TECLA_ACTIVA
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(DEBOUNCE);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HELD     = 3'd2,
    ST_RELEASE  = 3'd3
  } state_t;

  state_t        state;
  logic [3:0]    sync1;
  logic [3:0]    fs;
  logic [1:0]    col;
  logic [1:0]    col_nxt;
  logic [1:0]    row;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb;

  assign col_nxt = col + 2'd1;

  // Highest set bit index; only ever applied to a one-hot vector.
  function automatic logic [1:0] row_index(input logic [3:0] v);
    row_index = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) row_index = 2'(i);
    end
  endfunction

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= 4'b0000;
      fs    <= 4'b0000;
    end else begin
      sync1 <= FILAS;
      fs    <= sync1;
    end
  end

  // Scan / debounce / held / release controller with registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_SCAN;
      col          <= 2'd0;
      row          <= 2'd0;
      dwell        <= '0;
      deb          <= '0;
      COLUMNAS     <= 4'b0001;
      DIGITO       <= 4'd0;
      DIGITO_STB   <= 1'b0;
      TECLA_ACTIVA <= 1'b0;
    end else begin
      DIGITO_STB <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (dwell == DWELL_LAST) begin
            if ($onehot(fs)) begin
              // Single row on this column: freeze the column and debounce it.
              row   <= row_index(fs);
              deb   <= '0;
              state <= ST_DEBOUNCE;
            end else begin
              // Nothing, or ambiguous multi-row reading: keep scanning.
              col      <= col_nxt;
              COLUMNAS <= 4'b0001 << col_nxt;
              dwell    <= '0;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        ST_DEBOUNCE: begin
          if (fs == (4'b0001 << row)) begin
            if (deb == DEB_LAST) begin
              DIGITO       <= {row, col};
              DIGITO_STB   <= 1'b1;
              TECLA_ACTIVA <= 1'b1;
              deb          <= '0;
              state        <= ST_HELD;
            end else begin
              deb <= deb + 1'b1;
            end
          end else begin
            col      <= col_nxt;
            COLUMNAS <= 4'b0001 << col_nxt;
            dwell    <= '0;
            state    <= ST_SCAN;
          end
        end

        ST_HELD: begin
          if (!fs[row]) begin
            deb   <= '0;
            state <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (!fs[row]) begin
            if (deb == DEB_LAST) begin
              TECLA_ACTIVA <= 1'b0;
              col          <= col_nxt;
              COLUMNAS     <= 4'b0001 << col_nxt;
              dwell        <= '0;
              deb          <= '0;
              state        <= ST_SCAN;
            end else begin
              deb <= deb + 1'b1;
            end
          end else begin
            // Key bounced back before the release was confirmed.
            state <= ST_HELD;
          end
        end

        default: begin
          state        <= ST_SCAN;
          col          <= 2'd0;
          row          <= 2'd0;
          dwell        <= '0;
          deb          <= '0;
          COLUMNAS     <= 4'b0001;
          DIGITO       <= 4'd0;
          TECLA_ACTIVA <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_teclado_escaner.sv
// Self-checking bench for teclado_escaner: keypad matrix model, directed
// vectors, multi-cycle corner sequences and randomized presses.
module tb_teclado_escaner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] FILAS;
  logic [3:0] COLUMNAS;
  logic [3:0] DIGITO;
  logic       DIGITO_STB;
  logic       TECLA_ACTIVA;

  // Pressed keys, bit index = 4*row + col.
  logic [15:0] keys = 16'h0000;

  int tests = 0;
  int fails = 0;
  int stb_cnt = 0;
  int fall_cnt = 0;
  int consec = 0;
  logic [3:0] last_code = 4'd0;
  logic prev_stb = 1'b0;
  logic prev_tecla = 1'b0;

  teclado_escaner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .FILAS(FILAS),
    .COLUMNAS(COLUMNAS),
    .DIGITO(DIGITO),
    .DIGITO_STB(DIGITO_STB),
    .TECLA_ACTIVA(TECLA_ACTIVA)
  );

  always #5 CLK = ~CLK;

  // Passive keypad: a row reads high when a pressed key sits on a driven column.
  always_comb begin
    FILAS = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && COLUMNAS[c]) FILAS[r] = 1'b1;
  end

  // Event monitor sampled just after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (DIGITO_STB === 1'b1) begin
      stb_cnt++;
      last_code = DIGITO;
      if (prev_stb) consec++;
    end
    prev_stb = (DIGITO_STB === 1'b1);
    if (prev_tecla && TECLA_ACTIVA !== 1'b1) fall_cnt++;
    prev_tecla = (TECLA_ACTIVA === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_cols(input logic [3:0] v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      if (COLUMNAS == v) ok = 1'b1;
    end
  endtask

  task automatic wait_tecla(input logic v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      if (TECLA_ACTIVA == v) ok = 1'b1;
    end
  endtask

  task automatic wait_stb(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      if (stb_cnt >= target) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          exp_cnt;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int s0, f0, good, bad, r, c, hold, exp_n;
    bit long_press;
    logic [3:0] prev_cols;

    vecs[0] = '{16'h0200, 200, 1, 4'd9};   // row 2, col 1
    vecs[1] = '{16'h0001, 60,  1, 4'd0};   // row 0, col 0
    vecs[2] = '{16'h8000, 60,  1, 4'd15};  // row 3, col 3
    vecs[3] = '{16'h1000, 60,  1, 4'd12};  // row 3, col 0
    vecs[4] = '{16'h0040, 60,  1, 4'd6};   // row 1, col 2
    vecs[5] = '{16'h0008, 5,   0, 4'd0};   // tap too short to debounce

    // Reset values while RESET is held.
    cyc(3);
    check("reset_columnas", 32'(COLUMNAS), 32'd1);
    check("reset_digito", 32'(DIGITO), 32'd0);
    check("reset_stb", 32'(DIGITO_STB), 32'd0);
    check("reset_tecla", 32'(TECLA_ACTIVA), 32'd0);
    RESET = 1'b0;
    cyc(5);

    // Asynchronous reset while a key is held.
    keys = 16'h0200;
    wait_tecla(1'b1, 80, ok);
    check("t1_held_reached", 32'(ok), 32'd1);
    cyc(3);
    #1 RESET = 1'b1;
    #1;
    check("t1_async_columnas", 32'(COLUMNAS), 32'd1);
    check("t1_async_tecla", 32'(TECLA_ACTIVA), 32'd0);
    check("t1_async_digito", 32'(DIGITO), 32'd0);
    keys = 16'h0000;
    @(negedge CLK);
    RESET = 1'b0;
    cyc(30);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      s0 = stb_cnt;
      f0 = fall_cnt;
      keys = vecs[i].keys;
      cyc(vecs[i].hold);
      keys = 16'h0000;
      if (vecs[i].exp_cnt == 1) begin
        check($sformatf("v%0d_tecla_at_release", i), 32'(TECLA_ACTIVA), 32'd1);
        cyc(8);
        check($sformatf("v%0d_tecla_8_after", i), 32'(TECLA_ACTIVA), 32'd1);
        cyc(22);
        check($sformatf("v%0d_code", i), 32'(last_code), 32'(vecs[i].exp_code));
      end else begin
        cyc(30);
      end
      check($sformatf("v%0d_strobes", i), 32'(stb_cnt - s0), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_falls", i), 32'(fall_cnt - f0), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_tecla_idle", i), 32'(TECLA_ACTIVA), 32'd0);
    end

    // One-cycle drop during debounce of row 0 / col 3.
    wait_cols(4'b0100, 40, ok);
    check("t3_sync_c2", 32'(ok), 32'd1);
    keys = 16'h0008;
    wait_cols(4'b1000, 40, ok);
    check("t3_sync_c3", 32'(ok), 32'd1);
    s0 = stb_cnt;
    cyc(5);
    keys = 16'h0000;
    cyc(1);
    keys = 16'h0008;
    cyc(10);
    check("t3_no_first_strobe", 32'(stb_cnt - s0), 32'd0);
    wait_stb(s0 + 1, 80, ok);
    check("t3_second_pass_strobe", 32'(ok), 32'd1);
    check("t3_code", 32'(last_code), 32'd3);
    keys = 16'h0000;
    cyc(30);

    // Two rows on one column: ignored, scanning keeps rotating.
    s0 = stb_cnt;
    good = 0;
    bad = 0;
    keys = 16'h4040;
    prev_cols = COLUMNAS;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (COLUMNAS != prev_cols) begin
        if (COLUMNAS == {prev_cols[2:0], prev_cols[3]}) good++;
        else bad++;
      end
      prev_cols = COLUMNAS;
    end
    keys = 16'h0000;
    check("t4_no_strobe", 32'(stb_cnt - s0), 32'd0);
    check("t4_rotations", 32'(good >= 20), 32'd1);
    check("t4_bad_rotations", 32'(bad), 32'd0);
    cyc(20);

    // Held key 5: short glitch, full release, re-press.
    s0 = stb_cnt;
    keys = 16'h0020;
    wait_tecla(1'b1, 80, ok);
    check("t5_accept", 32'(ok), 32'd1);
    cyc(2);
    keys = 16'h0000;
    cyc(3);
    keys = 16'h0020;
    cyc(15);
    check("t5_glitch_no_strobe", 32'(stb_cnt - s0), 32'd1);
    check("t5_glitch_tecla", 32'(TECLA_ACTIVA), 32'd1);
    f0 = fall_cnt;
    keys = 16'h0000;
    cyc(10);
    keys = 16'h0020;
    wait_stb(s0 + 2, 80, ok);
    check("t5_repress_strobe", 32'(ok), 32'd1);
    check("t5_release_fall", 32'(fall_cnt - f0), 32'd1);
    check("t5_code", 32'(last_code), 32'd5);
    keys = 16'h0000;
    cyc(30);

    // Reset in the middle of debouncing key 0xF.
    wait_cols(4'b0100, 40, ok);
    check("t6_sync_c2", 32'(ok), 32'd1);
    keys = 16'h8000;
    wait_cols(4'b1000, 40, ok);
    check("t6_sync_c3", 32'(ok), 32'd1);
    s0 = stb_cnt;
    cyc(8);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    cyc(1);
    check("t6_no_strobe", 32'(stb_cnt - s0), 32'd0);
    check("t6_digito_zero", 32'(DIGITO), 32'd0);
    wait_stb(s0 + 1, 80, ok);
    check("t6_rescan_strobe", 32'(ok), 32'd1);
    check("t6_code", 32'(last_code), 32'd15);
    keys = 16'h0000;
    cyc(30);

    // Randomized single presses: long ones give one strobe with code 4*row+col,
    // taps shorter than the debounce window give none.
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      long_press = ($urandom_range(0, 3) != 0);
      hold = long_press ? $urandom_range(40, 90) : $urandom_range(1, 7);
      exp_n = long_press ? 1 : 0;
      s0 = stb_cnt;
      keys = 16'(1) << (4*r + c);
      cyc(hold);
      keys = 16'h0000;
      cyc(30);
      check($sformatf("rnd%0d_strobes", t), 32'(stb_cnt - s0), 32'(exp_n));
      if (long_press)
        check($sformatf("rnd%0d_code", t), 32'(last_code), 32'(4*r + c));
      check($sformatf("rnd%0d_tecla_idle", t), 32'(TECLA_ACTIVA), 32'd0);
    end

    check("stb_never_consecutive", 32'(consec), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
